// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Holds the port-owner encoding, the default starvation limit, the wait
// counter width and a helper that derives B's effective write enables.
// Optional feature macro used by the arbiter files: DMEM_ARB_FAIRNESS_EN.
package dmem_arbiter_pkg;

  typedef enum logic {
    ARB_OWNER_A = 1'b0,
    ARB_OWNER_B = 1'b1
  } arb_owner_e;

  localparam int DMEM_ARB_MAX_WAIT_DEFAULT = 8;
  localparam int DMEM_ARB_WAIT_W           = 8;

  // A B read must never write, so its byte enables collapse to zero.
  function automatic logic [3:0] b_mark_eff(input logic we, input logic [3:0] mark);
    return we ? mark : 4'b0000;
  endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating starvation counter for port B of the data-memory arbiter.
// Counts consecutive cycles in which B is pending but refused, and raises
// force_b_o once the count reaches MAX_WAIT so B gets one forced grant.
// Only instantiated when DMEM_ARB_FAIRNESS_EN is defined.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   b_valid_i    : B request pending
//   grant_b_i    : B owns the memory port this cycle
//   force_b_o    : B must be granted this cycle
module dmem_arb_starve_cnt
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DMEM_ARB_MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic b_valid_i,
  input  logic grant_b_i,
  output logic force_b_o
);

  localparam logic [DMEM_ARB_WAIT_W-1:0] MaxWaitC = DMEM_ARB_WAIT_W'(MAX_WAIT);

  logic [DMEM_ARB_WAIT_W-1:0] wait_cnt_q;
  logic [DMEM_ARB_WAIT_W-1:0] wait_cnt_d;

  // A grant or a withdrawn request restarts the window; otherwise count
  // refusals and hold at the limit until B is finally served.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!b_valid_i || grant_b_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MaxWaitC) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign force_b_o = (wait_cnt_q == MaxWaitC);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the MEM stage (port A, primary owner)
// and an auxiliary word master (port B, valid/ready handshake).
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   a_req/a_add/a_byte_mark/a_data_write: MEM stage access (mark 0 = read)
//   a_stall_o                           : A refused this cycle, hold pipeline
//   a_rdata_o                           : read data returned to A
//   b_valid/b_we/b_add/b_byte_mark/b_data_write : B request
//   b_ready_o                           : B request accepted this cycle
//   b_rvalid_o/b_rdata_o                : B read return, one cycle later
//   DMEM_add_o/DMEM_byte_mark_o/DMEM_data_write_o : memory request
//   DMEM_data_i                         : memory read data (1-cycle latency)
// Optional feature: define DMEM_ARB_FAIRNESS_EN to compile in the
// starvation counter that forces a B grant after MAX_WAIT refusals.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT   = DMEM_ARB_MAX_WAIT_DEFAULT,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_add,
  input  logic [3:0]            a_byte_mark,
  input  logic [31:0]           a_data_write,
  output logic                  a_stall_o,
  input  logic                  b_valid,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_add,
  input  logic [3:0]            b_byte_mark,
  input  logic [31:0]           b_data_write,
  output logic                  b_ready_o,
  output logic                  b_rvalid_o,
  output logic [31:0]           b_rdata_o,
  output logic [ADDR_WIDTH-1:0] DMEM_add_o,
  output logic [3:0]            DMEM_byte_mark_o,
  output logic [31:0]           DMEM_data_write_o,
  input  logic [31:0]           DMEM_data_i,
  output logic [31:0]           a_rdata_o
);

  logic       force_b;
  logic       grant_b;
  arb_owner_e owner;
  logic       rd_owner_b_q;
  logic       rd_owner_b_d;
  logic       unused_b_add_lo;

  assign unused_b_add_lo = ^b_add[1:0];

`ifdef DMEM_ARB_FAIRNESS_EN
  dmem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .b_valid_i (b_valid),
    .grant_b_i (grant_b),
    .force_b_o (force_b)
  );
`else
  // Without fairness B only ever fills idle A cycles.
  logic [7:0] unused_max_wait;
  assign unused_max_wait = 8'(MAX_WAIT);
  assign force_b         = 1'b0;
`endif

  assign grant_b   = b_valid & (~a_req | force_b);
  assign owner     = grant_b ? ARB_OWNER_B : ARB_OWNER_A;
  assign b_ready_o = grant_b;
  assign a_stall_o = a_req & grant_b;

  // Memory request mux. Write enables are held low during reset so the
  // memory cannot be corrupted while the rest of the system is resetting.
  always_comb begin
    DMEM_add_o        = a_add;
    DMEM_byte_mark_o  = a_byte_mark;
    DMEM_data_write_o = a_data_write;
    if (owner == ARB_OWNER_B) begin
      DMEM_add_o        = {b_add[ADDR_WIDTH-1:2], 2'b00};
      DMEM_byte_mark_o  = b_mark_eff(b_we, b_byte_mark);
      DMEM_data_write_o = b_data_write;
    end
    if (!rst_n) begin
      DMEM_byte_mark_o = 4'b0000;
    end
  end

  // Remember whether the word arriving next cycle belongs to a B read.
  assign rd_owner_b_d = grant_b & ~b_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner_b_q <= 1'b0;
    end else begin
      rd_owner_b_q <= rd_owner_b_d;
    end
  end

  assign b_rvalid_o = rd_owner_b_q;
  assign b_rdata_o  = rd_owner_b_q ? DMEM_data_i : 32'h0;
  assign a_rdata_o  = DMEM_data_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random
// traffic checked against a cycle-level behavioural model of the arbiter
// rules and a scoreboard copy of memory.
module tb_dmem_arbiter;

  localparam int MAXW = 3;
`ifdef DMEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic        aReq, bValid, bWe;
  logic [31:0] aAdd, aData, bAdd, bData;
  logic [3:0]  aMark, bMark;
  logic        aStall, bReady, bRvalid;
  logic [31:0] bRdata, dmemAdd, dmemWdata, aRdata;
  logic [3:0]  dmemMark;
  logic [31:0] memRdQ;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] mem    [1024];
  logic [31:0] refMem [1024];
  int          streak;
  bit          pendB, rdKnown;
  logic [31:0] lastRd;
  bit          expGrant, expStall, expBRvalid;
  logic [31:0] expAdd, expWdata, expBRdata, expARdata;
  logic [3:0]  expMark;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MAXW), .ADDR_WIDTH(32)) dut (
    .clk               (clk),
    .rst_n             (rstN),
    .a_req             (aReq),
    .a_add             (aAdd),
    .a_byte_mark       (aMark),
    .a_data_write      (aData),
    .a_stall_o         (aStall),
    .b_valid           (bValid),
    .b_we              (bWe),
    .b_add             (bAdd),
    .b_byte_mark       (bMark),
    .b_data_write      (bData),
    .b_ready_o         (bReady),
    .b_rvalid_o        (bRvalid),
    .b_rdata_o         (bRdata),
    .DMEM_add_o        (dmemAdd),
    .DMEM_byte_mark_o  (dmemMark),
    .DMEM_data_write_o (dmemWdata),
    .DMEM_data_i       (memRdQ),
    .a_rdata_o         (aRdata)
  );

  // Physical memory: synchronous read of the old word, byte-lane writes.
  always @(posedge clk) begin
    memRdQ <= mem[dmemAdd[11:2]];
    for (int b = 0; b < 4; b++)
      if (dmemMark[b]) mem[dmemAdd[11:2]][8*b +: 8] <= dmemWdata[8*b +: 8];
  end

  // B must hold its request until it is accepted.
  assert property (@(posedge clk) disable iff (!rstN) (bValid && !bReady) |=> bValid)
    else $error("[TB] B dropped b_valid before acceptance");

  // Compute what the arbiter must present this cycle, then move to the
  // sampling point away from the active edge.
  task automatic evalCycle();
    if (!rstN) begin
      pendB  = 1'b0;
      streak = 0;
    end
    expGrant   = bValid && (!aReq || (FAIR && streak == MAXW));
    expStall   = aReq && expGrant;
    expAdd     = expGrant ? {bAdd[31:2], 2'b00} : aAdd;
    expWdata   = expGrant ? bData : aData;
    expMark    = !rstN ? 4'b0 : (expGrant ? (bWe ? bMark : 4'b0) : aMark);
    expBRvalid = pendB;
    expBRdata  = pendB ? lastRd : 32'h0;
    expARdata  = lastRd;
    @(negedge clk);
  endtask

  // Advance the model across the clock edge.
  task automatic commitCycle();
    @(posedge clk);
    lastRd  = refMem[expAdd[11:2]];
    rdKnown = 1'b1;
    for (int b = 0; b < 4; b++)
      if (expMark[b]) refMem[expAdd[11:2]][8*b +: 8] = expWdata[8*b +: 8];
    if (rstN) begin
      pendB = expGrant && !bWe;
      if (!bValid || expGrant) streak = 0;
      else if (streak < MAXW)  streak = streak + 1;
    end else begin
      pendB  = 1'b0;
      streak = 0;
    end
    #1;
  endtask

  task automatic applyStimulus(input bit ar, input logic [31:0] aa, input logic [3:0] am,
                               input bit bv, input bit bw, input logic [31:0] ba,
                               input logic [3:0] bm, input logic [31:0] bd);
    aReq = ar; aAdd = aa; aMark = am; aData = 32'hA5A5_0000 ^ aa;
    bValid = bv; bWe = bw; bAdd = ba; bMark = bm; bData = bd;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h1234_5678);
    evalCycle();
    checks++;
    if (dmemMark !== 4'b0) begin
      errors++; $display("[TB] FAIL reset_mark: got %h expected 0", dmemMark);
    end
    checks++;
    if (bRvalid !== 1'b0 || bRdata !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_rvalid: got %b/%h expected 0/0", bRvalid, bRdata);
    end
    commitCycle();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    evalCycle();
    commitCycle();
    rstN = 1'b1;
    evalCycle();
    checks++;
    if (bRvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL release_rvalid: got %b expected 0", bRvalid);
    end
    commitCycle();
  endtask

  task automatic test_a_only();
    applyStimulus(1'b1, 32'h100, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    evalCycle();
    checks++;
    if (dmemAdd !== 32'h100 || aStall !== 1'b0 || dmemMark !== 4'h0) begin
      errors++;
      $display("[TB] FAIL a_only_req: got add %h stall %b mark %h expected 100/0/0", dmemAdd, aStall, dmemMark);
    end
    commitCycle();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    evalCycle();
    checks++;
    if (aRdata !== refMem[32'h100 >> 2]) begin
      errors++; $display("[TB] FAIL a_only_rdata: got %h expected %h", aRdata, refMem[32'h100 >> 2]);
    end
    commitCycle();
  endtask

  task automatic test_b_write_read();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h204, 4'hF, 32'hDEAD_BEEF);
    evalCycle();
    checks++;
    if (bReady !== 1'b1 || dmemAdd !== 32'h204 || dmemMark !== 4'hF || dmemWdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL b_write: got rdy %b add %h mark %h data %h expected 1/204/f/deadbeef",
               bReady, dmemAdd, dmemMark, dmemWdata);
    end
    commitCycle();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h207, 4'hF, 32'h0);
    evalCycle();
    checks++;
    if (bReady !== 1'b1 || dmemAdd !== 32'h204 || dmemMark !== 4'h0) begin
      errors++;
      $display("[TB] FAIL b_read_req: got rdy %b add %h mark %h expected 1/204/0", bReady, dmemAdd, dmemMark);
    end
    commitCycle();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    evalCycle();
    checks++;
    if (bRvalid !== 1'b1 || bRdata !== 32'hDEAD_BEEF) begin
      errors++; $display("[TB] FAIL b_read_ret: got %b/%h expected 1/deadbeef", bRvalid, bRdata);
    end
    commitCycle();
  endtask

  // Entered with the starvation window known to be clear.
  task automatic test_conflict();
`ifdef DMEM_ARB_FAIRNESS_EN
    bit expRdy [6] = '{0, 0, 0, 1, 0, 0};
`else
    bit expRdy [6] = '{0, 0, 0, 0, 0, 0};
`endif
    applyStimulus(1'b1, 32'h10, 4'h0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      evalCycle();
      checks++;
      if (bReady !== expRdy[c] || aStall !== expRdy[c]) begin
        errors++;
        $display("[TB] FAIL conflict_c%0d: got rdy %b stall %b expected %b", c + 1, bReady, aStall, expRdy[c]);
      end
      commitCycle();
    end
    aReq = 1'b0;
    evalCycle();
    checks++;
    if (bReady !== 1'b1 || aStall !== 1'b0) begin
      errors++; $display("[TB] FAIL conflict_a_drop: got rdy %b stall %b expected 1/0", bReady, aStall);
    end
    commitCycle();
    bValid = 1'b0;
    evalCycle();
    commitCycle();
  endtask

  task automatic test_reset_mid_read();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
    evalCycle();
    checks++;
    if (bReady !== 1'b1) begin
      errors++; $display("[TB] FAIL midrd_grant: got %b expected 1", bReady);
    end
    commitCycle();
    rstN = 1'b0;
    applyStimulus(1'b1, 32'h40, 4'hF, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    evalCycle();
    checks++;
    if (bRvalid !== 1'b0 || dmemMark !== 4'h0) begin
      errors++; $display("[TB] FAIL midrd_reset: got rvalid %b mark %h expected 0/0", bRvalid, dmemMark);
    end
    commitCycle();
    rstN = 1'b1;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    evalCycle();
    checks++;
    if (bRvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL midrd_release: got %b expected 0", bRvalid);
    end
    commitCycle();
    // A cleared wait counter shows up as a full refusal window again.
    test_conflict();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      if (c < 3) applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'(4 * c), 4'h0, 32'h0);
      else       applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      evalCycle();
      if (c < 3) begin
        checks++;
        if (bReady !== 1'b1) begin
          errors++; $display("[TB] FAIL b2b_ready%0d: got %b expected 1", c, bReady);
        end
      end
      if (c > 0) begin
        checks++;
        if (bRvalid !== 1'b1 || bRdata !== refMem[c - 1]) begin
          errors++;
          $display("[TB] FAIL b2b_data%0d: got %b/%h expected 1/%h", c - 1, bRvalid, bRdata, refMem[c - 1]);
        end
      end
      commitCycle();
    end
  endtask

  task automatic test_random();
    int bad;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int c = 0; c < 400; c++) begin
      aReq  = ($urandom_range(0, 9) < 6);
      aAdd  = 32'($urandom_range(0, 1023)) << 2;
      aMark = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      aData = $urandom;
      if (!(bValid && !expGrant) || c == 0) begin
        bValid = ($urandom_range(0, 1) == 1);
        bWe    = ($urandom_range(0, 1) == 1);
        bAdd   = 32'($urandom_range(0, 4095));
        bMark  = 4'($urandom);
        bData  = $urandom;
      end
      evalCycle();
      bad = 0;
      checks++;
      if (bReady !== expGrant || aStall !== expStall) begin
        bad = 1; $display("[TB] FAIL rnd_grant c%0d: got rdy %b stall %b expected %b/%b", c, bReady, aStall, expGrant, expStall);
      end
      checks++;
      if (dmemAdd !== expAdd || dmemMark !== expMark || dmemWdata !== expWdata) begin
        bad = 1;
        $display("[TB] FAIL rnd_mux c%0d: got %h/%h/%h expected %h/%h/%h", c, dmemAdd, dmemMark, dmemWdata, expAdd, expMark, expWdata);
      end
      checks++;
      if (bRvalid !== expBRvalid || bRdata !== expBRdata) begin
        bad = 1;
        $display("[TB] FAIL rnd_bret c%0d: got %b/%h expected %b/%h", c, bRvalid, bRdata, expBRvalid, expBRdata);
      end
      if (rdKnown) begin
        checks++;
        if (aRdata !== expARdata) begin
          bad = 1; $display("[TB] FAIL rnd_ardata c%0d: got %h expected %h", c, aRdata, expARdata);
        end
      end
      errors += bad;
      commitCycle();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
      refMem[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    end
    streak  = 0;
    pendB   = 1'b0;
    rdKnown = 1'b0;
    lastRd  = 32'h0;
    expGrant = 1'b0;
    rstN = 1'b0;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    $display("[TB] start, fairness=%0d", FAIR);
    test_reset();
    test_a_only();
    test_b_write_read();
    test_conflict();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
